// File: rtl/morse_char_decoder_pkg.sv
// morse_pkg: shared FSM states, symbol encoding and the Morse-to-ASCII table.
package morse_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;
    localparam int MAX_SYMBOLS_DEF = 6;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;
    localparam logic DOT_BIT = 1'b0;
    localparam logic DASH_BIT = 1'b1;
    // First symbol sits in the most significant of the len low bits of pat.
    function automatic logic [7:0] morse_lookup(input logic [2:0] len, input logic [5:0] pat);
        case ({len, pat})
            {3'd1, 6'b000000}: return "E";
            {3'd1, 6'b000001}: return "T";
            {3'd2, 6'b000000}: return "I";
            {3'd2, 6'b000001}: return "A";
            {3'd2, 6'b000010}: return "N";
            {3'd2, 6'b000011}: return "M";
            {3'd3, 6'b000000}: return "S";
            {3'd3, 6'b000001}: return "U";
            {3'd3, 6'b000010}: return "R";
            {3'd3, 6'b000011}: return "W";
            {3'd3, 6'b000100}: return "D";
            {3'd3, 6'b000101}: return "K";
            {3'd3, 6'b000110}: return "G";
            {3'd3, 6'b000111}: return "O";
            {3'd4, 6'b000000}: return "H";
            {3'd4, 6'b000001}: return "V";
            {3'd4, 6'b000010}: return "F";
            {3'd4, 6'b000100}: return "L";
            {3'd4, 6'b000110}: return "P";
            {3'd4, 6'b000111}: return "J";
            {3'd4, 6'b001000}: return "B";
            {3'd4, 6'b001001}: return "X";
            {3'd4, 6'b001010}: return "C";
            {3'd4, 6'b001011}: return "Y";
            {3'd4, 6'b001100}: return "Z";
            {3'd4, 6'b001101}: return "Q";
            {3'd5, 6'b001111}: return "1";
            {3'd5, 6'b000111}: return "2";
            {3'd5, 6'b000011}: return "3";
            {3'd5, 6'b000001}: return "4";
            {3'd5, 6'b000000}: return "5";
            {3'd5, 6'b010000}: return "6";
            {3'd5, 6'b011000}: return "7";
            {3'd5, 6'b011100}: return "8";
            {3'd5, 6'b011110}: return "9";
            {3'd5, 6'b011111}: return "0";
            default:           return ASCII_UNKNOWN;
        endcase
    endfunction
endpackage

// File: rtl/morse_char_decoder_if.sv
// morse_char_if: valid/ready character channel from the decoder to the UI stage.
interface morse_char_if;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] char_data;
    modport master (output char_valid, output char_data, input char_ready);
    modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/morse_char_decoder_lut.sv
// morse_lut: combinational {length, pattern} to ASCII, '?' for unknown or overflowed codes.
module morse_lut
    import morse_pkg::*;
#(
    parameter int W = MAX_SYMBOLS_DEF
) (
    input  logic [2:0]   i_len,
    input  logic [W-1:0] i_pattern,
    input  logic         i_bad,
    output logic [7:0]   o_char
);
    assign o_char = i_bad ? ASCII_UNKNOWN : morse_lookup(i_len, 6'(i_pattern));
endmodule

// File: rtl/morse_char_decoder.sv
// morse_char_decoder: collects dot/dash strobes and emits one ASCII character per letter gap
// over a valid/ready channel, buffering the next character's symbols while stalled.
module morse_char_decoder
    import morse_pkg::*;
#(
    parameter int MAX_SYMBOLS = MAX_SYMBOLS_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dot_pulse,
    input  logic             dash_pulse,
    input  logic             clear,
    input  logic [CNT_W-1:0] timeout_cycles,
    morse_char_if.master     chr,
    output logic [2:0]       sym_count,
    output logic             overflow
);
    state_t                 r_state;
    logic [MAX_SYMBOLS-1:0] r_pattern;
    logic [2:0]             r_sym_count;
    logic [CNT_W-1:0]       r_gap_cnt;
    logic                   r_bad;
    logic                   r_char_valid;
    logic [7:0]             r_char_data;
    logic                   r_overflow;
    logic [CNT_W-1:0]       w_t;
    logic                   w_sym;
    logic                   w_full;
    logic                   w_accept;
    logic                   w_expired;
    logic [7:0]             w_char;
    assign w_t       = (timeout_cycles == '0) ? CNT_W'(1) : timeout_cycles;
    assign w_sym     = dot_pulse | dash_pulse;
    assign w_full    = r_sym_count == 3'(MAX_SYMBOLS);
    assign w_accept  = w_sym && !w_full;
    assign w_expired = r_gap_cnt >= w_t;
    morse_lut #(.W(MAX_SYMBOLS)) u_lut (
        .i_len     (r_sym_count),
        .i_pattern (r_pattern),
        .i_bad     (r_bad),
        .o_char    (w_char)
    );
    // Dropped (overflow) symbols neither shift nor restart the gap, they only poison the character.
    always_ff @(posedge clk) begin
        r_overflow <= 1'b0;
        if (rst) begin
            r_state      <= IDLE;
            r_pattern    <= '0;
            r_sym_count  <= '0;
            r_gap_cnt    <= '0;
            r_bad        <= 1'b0;
            r_char_valid <= 1'b0;
            r_char_data  <= 8'h00;
        end else if (clear) begin
            r_state      <= IDLE;
            r_pattern    <= '0;
            r_sym_count  <= '0;
            r_gap_cnt    <= '0;
            r_bad        <= 1'b0;
            r_char_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pattern   <= {r_pattern[MAX_SYMBOLS-2:0], dash_pulse ? DASH_BIT : DOT_BIT};
                r_sym_count <= r_sym_count + 3'd1;
                r_gap_cnt   <= '0;
            end
            if (w_sym && w_full) begin
                r_overflow <= 1'b1;
                r_bad      <= 1'b1;
            end
            case (r_state)
                IDLE: if (w_accept) r_state <= COLLECT;
                COLLECT: begin
                    if (!w_accept && w_expired) begin
                        r_char_data  <= w_char;
                        r_char_valid <= 1'b1;
                        r_pattern    <= '0;
                        r_sym_count  <= '0;
                        r_gap_cnt    <= '0;
                        r_bad        <= 1'b0;
                        r_state      <= EMIT;
                    end else if (!w_accept) r_gap_cnt <= r_gap_cnt + CNT_W'(1);
                end
                default: begin
                    if (!w_accept && !w_expired) r_gap_cnt <= r_gap_cnt + CNT_W'(1);
                    // A pending character always re-enters through COLLECT, giving the one-cycle valid gap.
                    if (r_char_valid && chr.char_ready) begin
                        r_char_valid <= 1'b0;
                        r_state      <= (r_sym_count == '0 && !w_accept) ? IDLE : COLLECT;
                    end
                end
            endcase
        end
    end
    assign chr.char_valid = r_char_valid;
    assign chr.char_data  = r_char_data;
    assign sym_count      = r_sym_count;
    assign overflow       = r_overflow;
endmodule

// File: tb/tb_morse_char_decoder.sv
// tb_morse_char_decoder: directed checks of latency, stall, overflow, clear, back-to-back and reset.
module tb_morse_char_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dot_pulse = 1'b0;
    logic        dash_pulse = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] timeout_cycles = 32'd100;
    logic [2:0]  sym_count;
    logic        overflow;
    int          n_checks = 0;
    int          n_fails = 0;
    int          xfers = 0;
    morse_char_if chr ();
    morse_char_decoder #(.MAX_SYMBOLS(6), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .dot_pulse      (dot_pulse),
        .dash_pulse     (dash_pulse),
        .clear          (clear),
        .timeout_cycles (timeout_cycles),
        .chr            (chr),
        .sym_count      (sym_count),
        .overflow       (overflow)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (!rst && chr.char_valid && chr.char_ready) xfers++;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic sym(input logic d, input logic h);
        dot_pulse = d;
        dash_pulse = h;
        tick();
        dot_pulse = 1'b0;
        dash_pulse = 1'b0;
    endtask
    task automatic wait_valid(output int c);
        c = 0;
        while (!chr.char_valid && c < 500) begin
            tick();
            c++;
        end
    endtask
    initial begin
        int c;
        int x0;
        logic seen;
        logic stable;
        chr.char_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", chr.char_valid, 0);
        chk("rst_data", chr.char_data, 8'h00);
        chk("rst_count", sym_count, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        chr.char_ready = 1'b1;
        sym(1, 0);
        chk("a_count1", sym_count, 1);
        sym(0, 1);
        chk("a_count2", sym_count, 2);
        wait_valid(c);
        chk("a_latency", c, 101);
        chk("a_data", chr.char_data, 8'h41);
        tick();
        chk("a_one_cycle", chr.char_valid, 0);
        chr.char_ready = 1'b0;
        timeout_cycles = 32'd20;
        x0 = xfers;
        repeat (5) sym(0, 1);
        wait_valid(c);
        chk("z_latency", c, 21);
        chk("z_data", chr.char_data, 8'h30);
        stable = 1'b1;
        repeat (50) begin
            tick();
            if (!chr.char_valid || chr.char_data !== 8'h30) stable = 1'b0;
        end
        chk("z_stall_stable", stable, 1);
        chr.char_ready = 1'b1;
        tick();
        chk("z_drop", chr.char_valid, 0);
        repeat (30) tick();
        chk("z_single_xfer", xfers - x0, 1);
        chr.char_ready = 1'b0;
        repeat (6) sym(1, 0);
        chk("o_count6", sym_count, 6);
        chk("o_no_ovf", overflow, 0);
        sym(1, 0);
        chk("o_ovf_pulse", overflow, 1);
        chk("o_count_held", sym_count, 6);
        tick();
        chk("o_ovf_one", overflow, 0);
        wait_valid(c);
        chk("o_valid", chr.char_valid, 1);
        chk("o_data", chr.char_data, 8'h3F);
        chr.char_ready = 1'b1;
        tick();
        chr.char_ready = 1'b0;
        sym(1, 0);
        sym(0, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("c_count0", sym_count, 0);
        seen = 1'b0;
        repeat (30) begin
            tick();
            seen |= chr.char_valid;
        end
        chk("c_no_valid", seen, 0);
        sym(1, 1);
        wait_valid(c);
        chk("c_dash_wins", chr.char_data, 8'h54);
        chr.char_ready = 1'b1;
        tick();
        chr.char_ready = 1'b0;
        timeout_cycles = 32'd10;
        sym(1, 0);
        wait_valid(c);
        chk("b_data1", chr.char_data, 8'h45);
        sym(1, 0);
        chk("b_pending", sym_count, 1);
        repeat (15) tick();
        chk("b_still_valid", chr.char_valid, 1);
        x0 = xfers;
        chr.char_ready = 1'b1;
        tick();
        chk("b_gap_low", chr.char_valid, 0);
        tick();
        chk("b_second_valid", chr.char_valid, 1);
        chk("b_data2", chr.char_data, 8'h45);
        tick();
        chk("b_after", chr.char_valid, 0);
        chk("b_two_xfers", xfers - x0, 2);
        chr.char_ready = 1'b0;
        timeout_cycles = 32'd0;
        sym(1, 0);
        wait_valid(c);
        chk("t0_latency", c, 2);
        chk("t0_data", chr.char_data, 8'h45);
        chr.char_ready = 1'b1;
        tick();
        chr.char_ready = 1'b0;
        timeout_cycles = 32'd5;
        sym(0, 1);
        wait_valid(c);
        chk("r_valid_pre", chr.char_valid, 1);
        x0 = xfers;
        chr.char_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chr.char_ready = 1'b0;
        chk("r_valid", chr.char_valid, 0);
        chk("r_data", chr.char_data, 8'h00);
        chk("r_count", sym_count, 0);
        chk("r_ovf", overflow, 0);
        chk("r_no_xfer", xfers - x0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/morse_char_decoder.md
# morse_char_decoder

Converts the single-cycle dot/dash pulses produced by the button input stage into ASCII characters. A character is emitted after a configurable letter-gap of silence. The block sits between the button/Morse input stage and the decode/LCD UI stage. Output uses a valid/ready handshake, so the UI can stall while the LCD is busy without losing symbols that arrive in the meantime.

## Interface
Parameters:
- MAX_SYMBOLS, 6, longest accepted code (digits need 5, punctuation 6)
- CNT_W, 32, width of the gap counter and of timeout_cycles

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- dot_pulse  in  1  one-cycle dot strobe
- dash_pulse  in  1  one-cycle dash strobe
- clear  in  1  one-cycle discard strobe
- timeout_cycles  in  CNT_W  letter-gap length in clk cycles; sampled continuously
- char_valid  out  1  character available
- char_ready  in  1  consumer accepts character
- char_data  out  8  ASCII uppercase character
- sym_count  out  3  symbols collected for the character in progress
- overflow  out  1  one-cycle pulse when a symbol beyond MAX_SYMBOLS is dropped

## Operation
- Symbol capture: `pattern <= {pattern[MAX_SYMBOLS-2:0], bit}`, where dot=0 and dash=1. `sym_count` increments and `gap_cnt` clears on every accepted symbol.
- Same-cycle dot and dash: dash wins; the dot is dropped.
- States:
  - IDLE: `sym_count`=0. The first symbol moves to COLLECT.
  - COLLECT: `gap_cnt` increments each symbol-free cycle. When `gap_cnt` reaches `max(timeout_cycles,1)`, the decoded character is registered into `char_data`. Then `pattern`/`sym_count` clear and the state moves to EMIT.
  - EMIT:
    - `char_valid`=1; `char_data` is held stable until `char_valid && char_ready`.
    - Symbols arriving in EMIT accumulate into the cleared `pattern` for the next character. `gap_cnt` runs and saturates at the timeout.
    - On handshake, the next state depends on what is pending:
      - `sym_count`=0 → IDLE.
      - Gap not yet expired → COLLECT.
      - Gap expired → re-enter EMIT with the new character (`char_valid` drops for exactly one cycle).
- Lookup: pattern plus length map to A–Z and 0–9. Any unknown pattern → `'?'` (0x3F).
- Overflow: a symbol arriving when `sym_count`==MAX_SYMBOLS is dropped and `overflow` pulses. A sticky `bad` flag forces the character to `'?'`.
- `clear`: priority below `rst`, above everything else.
  - Drops `char_valid` the next cycle, even with `char_ready` high in the same cycle (no transfer).
  - Clears `pattern`, `sym_count`, `gap_cnt` and `bad`, and returns to IDLE.
  - Symbols in the same cycle as `clear` are discarded.
- Reset values: `char_valid`=0, `char_data`=0x00, `sym_count`=0, `overflow`=0, state IDLE.
- Reset mid-EMIT: the pending character is lost and no transfer occurs.

## Timing
- Last symbol sampled on edge t → `char_valid` high from edge t+T+1, where T=`max(timeout_cycles,1)`.
- Handshake completes on the edge where `char_valid && char_ready`. `char_valid` is low the following cycle unless the back-to-back case applies (low for exactly one cycle, then high).
- `char_valid` never depends combinationally on `char_ready`.
- `timeout_cycles` changes take effect on the next `gap_cnt` comparison. Lowering T below the current `gap_cnt` expires the gap on the next cycle.
- `sym_count` updates one cycle after the strobe edge. `overflow` is registered and high for one cycle.

## Structure
- Package `morse_pkg`:
  - state enum {IDLE, COLLECT, EMIT}
  - constants: `MAX_SYMBOLS` default, `ASCII_UNKNOWN`=8'h3F, dot/dash bit encoding
  - lookup function prototype
- Sub-module `morse_lut`: combinational {length, pattern} → ASCII, with `'?'` as the default.
- Top: FSM, shift register, gap counter, output register.

## Test plan
- T=100; dot, dash, hold `char_ready`=1 → `char_valid` rises 101 cycles after the dash, lasts one cycle, `char_data`=0x41 ('A').
- Five dashes, T=20, `char_ready`=0 for 50 cycles then 1 → `char_data`=0x30 ('0') held stable for the whole stall, single transfer.
- Seven dots → `overflow` pulses on the 7th dot, `sym_count` stays 6, `char_data`=0x3F.
- Dot, dash, then `clear` before timeout → no `char_valid`, `sym_count`=0 next cycle. Dot and dash in the same cycle → 0x54 ('T').
- Emit 'E', keep `char_ready`=0, send a dot and wait >T, then raise `char_ready` → two transfers of 0x45 separated by exactly one `char_valid`-low cycle.
- Assert `rst` during EMIT with `char_ready`=1 in the same cycle → no transfer; all outputs at reset values the next cycle.
